// File: rtl/mult_accum_stage_if.sv
// Handshake bundle between the multiplier wrapper side and the group accumulator.
// master drives products and output back-pressure; slave is the accumulator stage.
interface mult_accum_stage_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              acc_clr;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid, in_product, acc_clr, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_product, acc_clr, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/mult_accum_stage.sv
// mult_accum_stage: sums each group of COUNT unsigned products into an ACC_W
// accumulator and hands the group sum downstream through a one-entry output
// register with valid/ready and a per-group sticky overflow flag.
module mult_accum_stage #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4
) (
    input logic             clk,
    input logic             rst_n,
    mult_accum_stage_if.slave bus
);
    localparam int CNT_W = $clog2(COUNT + 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;

    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic             out_ovf_q;

    logic             in_ready;
    logic             accept;
    logic             group_end;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_n;
    logic [CNT_W-1:0] cnt_base;
    logic             ovf_base;
    logic             ovf_n;
    logic             carry;

    // Ready depends only on the output register and downstream ready, never on in_valid.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Next-sum datapath; acc_clr swaps the running state for zero so a product
    // accepted alongside it becomes the first term of a fresh group.
    always_comb begin
        acc_base  = bus.acc_clr ? '0   : acc;
        cnt_base  = bus.acc_clr ? '0   : cnt;
        ovf_base  = bus.acc_clr ? 1'b0 : ovf_acc;
        {carry, acc_n} = {1'b0, acc_base}
                       + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_product};
        ovf_n     = ovf_base | carry;
        group_end = accept && (cnt_base == CNT_W'(COUNT - 1));
    end

    // Running group state: advance on accept, restart on group end or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (accept) begin
            if (group_end) begin
                acc     <= '0;
                cnt     <= '0;
                ovf_acc <= 1'b0;
            end else begin
                acc     <= acc_n;
                cnt     <= cnt_base + CNT_W'(1);
                ovf_acc <= ovf_n;
            end
        end else if (bus.acc_clr) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end
    end

    // Output register: load a completed group, otherwise drop valid once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (group_end) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= acc_n;
            out_ovf_q   <= ovf_n;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mult_accum_stage.sv
// Bench for mult_accum_stage: a 16-bit and a 9-bit accumulator instance share
// one stimulus stream; group results are checked through per-instance queues.
module tb_mult_accum_stage;
    logic clk;
    logic rst_n;

    mult_accum_stage_if #(.PROD_W(8), .ACC_W(16)) m16 ();
    mult_accum_stage_if #(.PROD_W(8), .ACC_W(9))  m9 ();

    assign m9.in_valid   = m16.in_valid;
    assign m9.in_product = m16.in_product;
    assign m9.acc_clr    = m16.acc_clr;
    assign m9.out_ready  = m16.out_ready;

    mult_accum_stage #(.PROD_W(8), .ACC_W(16), .COUNT(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m16)
    );

    mult_accum_stage #(.PROD_W(8), .ACC_W(9), .COUNT(4)) u_dut9 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int ovf;
    } exp_t;

    typedef struct {
        int p0, p1, p2, p3;
        int s16, o16, s9, o9;
    } vec_t;

    exp_t q16[$];
    exp_t q9[$];
    int   total = 0;
    int   bad   = 0;
    int   stalls = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int s16, input int o16, input int s9, input int o9);
        exp_t e;
        e.sum = s16; e.ovf = o16; q16.push_back(e);
        e.sum = s9;  e.ovf = o9;  q9.push_back(e);
    endtask

    // Called right after a falling edge; returns right after the falling edge
    // that follows the accepting rising edge.
    task automatic send(input int p, input bit clr);
        int n;
        n = 0;
        m16.in_valid   = 1'b1;
        m16.in_product = 8'(p);
        m16.acc_clr    = clr;
        #1;
        while (!m16.in_ready && n < 100) begin
            @(negedge clk);
            m16.acc_clr = 1'b0;
            #1;
            n++;
            stalls++;
        end
        if (!m16.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", n);
        end
        @(negedge clk);
        m16.in_valid = 1'b0;
        m16.acc_clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: compare each drained group against the queued expectation.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n && m16.out_valid && m16.out_ready) begin
            if (q16.size() == 0) begin
                total++; bad++;
                $display("FAIL sb16_unexpected: got sum=%0d, required no output", m16.out_sum);
            end else begin
                e = q16.pop_front();
                check("sb16_sum", int'(m16.out_sum), e.sum);
                check("sb16_ovf", int'(m16.out_ovf), e.ovf);
            end
        end
        if (rst_n && m9.out_valid && m9.out_ready) begin
            if (q9.size() == 0) begin
                total++; bad++;
                $display("FAIL sb9_unexpected: got sum=%0d, required no output", m9.out_sum);
            end else begin
                e = q9.pop_front();
                check("sb9_sum", int'(m9.out_sum), e.sum);
                check("sb9_ovf", int'(m9.out_ovf), e.ovf);
            end
        end
    end

    vec_t tbl[8];

    initial begin
        tbl[0] = '{225, 225, 225, 225,  900, 0,  388, 1};
        tbl[1] = '{  1,   1,   1,   1,    4, 0,    4, 0};
        tbl[2] = '{  1,   2,   3,   4,   10, 0,   10, 0};
        tbl[3] = '{  5,   6,   7,   8,   26, 0,   26, 0};
        tbl[4] = '{255, 255,   1,   0,  511, 0,  511, 0};
        tbl[5] = '{255, 255,   2,   0,  512, 0,    0, 1};
        tbl[6] = '{  0,   0,   0,   0,    0, 0,    0, 0};
        tbl[7] = '{255, 255, 255, 255, 1020, 0,  508, 1};

        rst_n          = 1'b0;
        m16.in_valid   = 1'b0;
        m16.in_product = '0;
        m16.acc_clr    = 1'b0;
        m16.out_ready  = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_out_valid16", int'(m16.out_valid), 0);
        check("rst_out_sum16",   int'(m16.out_sum),   0);
        check("rst_out_ovf16",   int'(m16.out_ovf),   0);
        check("rst_in_ready16",  int'(m16.in_ready),  1);
        check("rst_out_valid9",  int'(m9.out_valid),  0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Output latency: one cycle after the 4th accept
        send(225, 1'b0);
        send(225, 1'b0);
        send(225, 1'b0);
        check("lat_before_valid", int'(m16.out_valid), 0);
        push(900, 0, 388, 1);
        send(225, 1'b0);
        check("lat_after_valid", int'(m16.out_valid), 1);
        check("lat_sum16", int'(m16.out_sum), 900);
        check("lat_ovf9",  int'(m9.out_ovf),  1);
        idle(2);

        // Table groups streamed back to back with downstream always ready
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].p0, 1'b0);
            send(tbl[i].p1, 1'b0);
            send(tbl[i].p2, 1'b0);
            push(tbl[i].s16, tbl[i].o16, tbl[i].s9, tbl[i].o9);
            send(tbl[i].p3, 1'b0);
        end
        check("stream_no_stall", stalls, 0);
        idle(3);
        check("stream_drained", int'(m16.out_valid), 0);

        // Back-pressure: group 10 held, product 5 waits upstream
        m16.out_ready = 1'b0;
        send(1, 1'b0);
        send(2, 1'b0);
        send(3, 1'b0);
        push(10, 0, 10, 0);
        send(4, 1'b0);
        m16.in_valid   = 1'b1;
        m16.in_product = 8'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready",  int'(m16.in_ready),  0);
            check("bp_out_valid", int'(m16.out_valid), 1);
            check("bp_out_sum",   int'(m16.out_sum),   10);
            @(negedge clk);
        end
        m16.out_ready = 1'b1;
        #1;
        check("bp_release_ready", int'(m16.in_ready), 1);
        @(negedge clk);
        m16.in_valid = 1'b0;
        #1;
        check("bp_drained", int'(m16.out_valid), 0);
        @(negedge clk);
        send(6, 1'b0);
        send(7, 1'b0);
        push(26, 0, 26, 0);
        send(8, 1'b0);
        idle(2);

        // acc_clr with a simultaneous accept starts a new group
        send(5, 1'b0);
        send(6, 1'b0);
        send(7, 1'b1);
        send(1, 1'b0);
        send(1, 1'b0);
        push(10, 0, 10, 0);
        send(1, 1'b0);
        idle(2);

        // acc_clr alone discards the partial group
        send(200, 1'b0);
        send(200, 1'b0);
        m16.acc_clr = 1'b1;
        @(negedge clk);
        m16.acc_clr = 1'b0;
        send(1, 1'b0);
        send(2, 1'b0);
        send(3, 1'b0);
        push(10, 0, 10, 0);
        send(4, 1'b0);
        idle(2);

        // Reset while an output is pending: cleared immediately, never emitted
        m16.out_ready = 1'b0;
        send(9, 1'b0);
        send(9, 1'b0);
        send(9, 1'b0);
        send(9, 1'b0);
        #1;
        check("pend_out_valid", int'(m16.out_valid), 1);
        check("pend_out_sum",   int'(m16.out_sum),   36);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid16", int'(m16.out_valid), 0);
        check("mid_rst_out_sum16",   int'(m16.out_sum),   0);
        check("mid_rst_out_ovf16",   int'(m16.out_ovf),   0);
        check("mid_rst_out_sum9",    int'(m9.out_sum),    0);
        check("mid_rst_in_ready",    int'(m16.in_ready),  1);
        @(negedge clk);
        rst_n = 1'b1;
        m16.out_ready = 1'b1;
        @(negedge clk);

        // Reset after two products of a group: partial sum is lost
        send(5, 1'b0);
        send(5, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(2, 1'b0);
        send(2, 1'b0);
        send(2, 1'b0);
        push(8, 0, 8, 0);
        send(2, 1'b0);
        idle(4);

        check("sb16_all_drained", q16.size(), 0);
        check("sb9_all_drained",  q9.size(),  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
